// File: rtl/fifo_uart_tx.sv
// Purpose : pops bytes from an 8-bit FIFO and sends each one as a UART 8N1 frame on tx.
// Latency : the pop is issued one cycle after IDLE sees data; the start bit begins two cycles after the pop.
//           Each frame lasts 10*CLKS_PER_BIT cycles.
// Backpr. : pops only from IDLE with enable high and the FIFO non-empty; a frame in flight always completes.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   enable      - permits a new frame to start (sampled only in IDLE)
//   fifo_empty  - FIFO empty flag (sampled only in IDLE)
//   fifo_data   - FIFO read data (sampled only in LATCH)
//   fifo_re     - FIFO read strobe, a one-cycle pulse per byte
//   tx          - serial line, idles high
//   busy        - high whenever the FSM is outside IDLE
//   byte_done   - one-cycle pulse during the last stop-bit cycle
//   sent_count  - completed frame count, wraps silently
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_re,
  output logic             tx,
  output logic             busy,
  output logic             byte_done,
  output logic [CNT_W-1:0] sent_count
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    baud, baud_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             tx_nxt, re_nxt, busy_nxt, done_nxt;
  logic             baud_end;

  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      fifo_re    <= 1'b0;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      sent_count <= '0;
    end else begin
      state      <= state_nxt;
      baud       <= baud_nxt;
      bit_idx    <= bit_idx_nxt;
      shift      <= shift_nxt;
      tx         <= tx_nxt;
      fifo_re    <= re_nxt;
      busy       <= busy_nxt;
      byte_done  <= done_nxt;
      sent_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud + BW'(1);
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;

    case (state)
      S_IDLE: begin
        baud_nxt = '0;
        if (enable && !fifo_empty) state_nxt = S_READ;
      end
      S_READ: begin
        baud_nxt  = '0;
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        // The FIFO presents the popped byte during this cycle.
        baud_nxt  = '0;
        shift_nxt = fifo_data;
        state_nxt = S_START;
      end
      S_START: begin
        if (baud_end) begin
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_nxt    = '0;
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        baud_nxt  = '0;
        state_nxt = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up exactly with the state they describe.
    re_nxt   = (state_nxt == S_READ);
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_STOP) && (baud_nxt == BAUD_LAST);
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase

    count_nxt = sent_count;
    if (done_nxt) count_nxt = sent_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int CW    = 2;
  localparam int FRAME = 10 * CPB;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          enable     = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [7:0]    fifo_data  = 8'h00;
  logic          fifo_re, tx, busy, byte_done;
  logic [CW-1:0] sent_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int frame_starts[$];
  int re_cycles[$];
  int sc_log[$];
  int re_cnt = 0, frames_done = 0, bd_cnt = 0, exp_cnt = 0;
  bit abort_req = 1'b0;
  int base_f, base_r, base_s;
  int exp_seq[5] = '{1, 2, 3, 0, 1};

  logic       mon_lvl;
  logic [7:0] mon_got;
  bit         mon_ok, mon_abort;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .tx         (tx),
    .busy       (busy),
    .byte_done  (byte_done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int t = 0;
    while (frames_done < target && t < budget) begin
      step(1);
      t++;
    end
    check("frame_wait_timeout", int'(frames_done >= target), 1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int t = 0;
    while (frame_starts.size() < target && t < budget) begin
      step(1);
      t++;
    end
    check("start_wait_timeout", int'(frame_starts.size() >= target), 1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    abort_req = 1'b1;
    exp_cnt   = 0;
    step(1);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_sent_count", int'(sent_count), 0);
    rst = 1'b0;
  endtask

  // FIFO behavioural model: a pop strobe during READ makes the next byte
  // visible on fifo_data for the following (LATCH) cycle.
  initial forever begin
    @(negedge clk);
    if (byte_done === 1'b1) bd_cnt++;
    if (fifo_re === 1'b1) begin
      re_cnt++;
      re_cycles.push_back(cyc);
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL pop_while_empty actual=fifo_re=1 required=no pop (cycle %0d)", cyc);
      end else begin
        fifo_data = fq.pop_front();
      end
    end
    fifo_empty = (fq.size() == 0);
  end

  // Line monitor: decodes every frame on tx and scores it against the
  // expected-byte queue and the frame-count model.
  initial forever begin
    @(negedge clk);
    if (abort_req) begin
      abort_req = 1'b0;
    end else if (tx === 1'b0) begin
      frame_starts.push_back(cyc);
      mon_ok    = 1'b1;
      mon_abort = 1'b0;
      mon_got   = 8'h00;
      mon_lvl   = 1'b0;
      for (int s = 0; s < FRAME; s++) begin
        if (s > 0) @(negedge clk);
        if (abort_req) begin
          abort_req = 1'b0;
          mon_abort = 1'b1;
          break;
        end
        if (s % CPB == 0) mon_lvl = tx;
        else if (tx !== mon_lvl) mon_ok = 1'b0;
        if (s < CPB && tx !== 1'b0) mon_ok = 1'b0;
        if (s >= 9 * CPB && tx !== 1'b1) mon_ok = 1'b0;
        if (s >= CPB && s < 9 * CPB && s % CPB == 0) mon_got[s / CPB - 1] = tx;
        if (busy !== 1'b1) mon_ok = 1'b0;
        if (byte_done !== (s == FRAME - 1)) mon_ok = 1'b0;
      end
      if (mon_abort) begin
        if (exp_q.size() > 0) mon_got = exp_q.pop_front();
      end else begin
        check("frame_shape", int'(mon_ok), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected actual=%02h required=no frame", mon_got);
        end else begin
          check("frame_data", int'(mon_got), int'(exp_q.pop_front()));
        end
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check("sent_count", int'(sent_count), exp_cnt);
        sc_log.push_back(int'(sent_count));
        frames_done++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    step(3);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_fifo_re", int'(fifo_re), 0);
    check("reset_byte_done", int'(byte_done), 0);
    check("reset_sent_count", int'(sent_count), 0);
    rst = 1'b0;

    // Single byte 0xA5
    base_f = frames_done;
    base_r = re_cnt;
    push_byte(8'hA5);
    enable = 1'b1;
    wait_frames(base_f + 1, 200);
    step(5);
    check("single_pops", re_cnt - base_r, 1);
    check("pop_to_start", frame_starts[frame_starts.size() - 1] - re_cycles[re_cycles.size() - 1], 2);
    check("single_count", int'(sent_count), 1);

    // Eight random bytes back-to-back
    base_f = frames_done;
    base_r = re_cnt;
    base_s = frame_starts.size();
    for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
    wait_frames(base_f + 8, 8 * (FRAME + 10));
    step(20);
    check("burst_pops", re_cnt - base_r, 8);
    for (int i = 1; i < 8; i++)
      check("burst_gap", frame_starts[base_s + i] - frame_starts[base_s + i - 1], FRAME + 3);
    check("burst_idle_busy", int'(busy), 0);

    // Empty FIFO with enable held
    for (int i = 0; i < 200; i++) begin
      step(1);
      check("empty_idle", int'({fifo_re, tx, busy}), 3'b010);
    end

    // Enable dropped during data bit 3 with two bytes queued
    base_f = frames_done;
    base_r = re_cnt;
    base_s = frame_starts.size();
    push_byte(8'($urandom_range(0, 255)));
    push_byte(8'($urandom_range(0, 255)));
    wait_starts(base_s + 1, 100);
    step(CPB * 4 + 1);
    enable = 1'b0;
    wait_frames(base_f + 1, 100);
    step(60);
    check("gated_pops", re_cnt - base_r, 1);
    check("gated_frames", frames_done - base_f, 1);
    check("gated_busy", int'(busy), 0);
    enable = 1'b1;
    wait_frames(base_f + 2, 100);
    check("gated_resume_pops", re_cnt - base_r, 2);

    // Reset during data bit 5 of 0x3C, then a clean frame
    step(5);
    base_f = frames_done;
    base_r = re_cnt;
    base_s = frame_starts.size();
    push_byte(8'h3C);
    push_byte(8'($urandom_range(0, 255)));
    wait_starts(base_s + 1, 100);
    step(CPB * 6 + 1);
    do_reset();
    wait_frames(base_f + 1, 150);
    step(5);
    check("reset_resume_pops", re_cnt - base_r, 2);
    check("reset_resume_frames", frames_done - base_f, 1);

    // Counter wrap with a 2-bit count
    do_reset();
    sc_log.delete();
    base_f = frames_done;
    for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
    wait_frames(base_f + 5, 5 * (FRAME + 10));
    for (int i = 0; i < 5; i++) check("wrap_seq", sc_log[i], exp_seq[i]);

    step(20);
    check("exp_drained", exp_q.size(), 0);
    check("fifo_drained", fq.size(), 0);
    check("byte_done_pulses", bd_cnt, frames_done);
    check("final_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
